// File: rtl/traffic_pkg.sv
// traffic_pkg -- shared definitions for the multi-phase traffic light controller.
//   state_e      : controller FSM states
//   LIGHT_*      : one-hot lamp encodings for a single approach (red 001, yellow 010, green 100)
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_PED    = 2'd3
  } state_e;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

endpackage

// File: rtl/tick_countdown.sv
// tick_countdown -- loadable down-counter advanced by a timebase enable.
//   clk      : clock
//   rst      : synchronous active-high reset, loads RST_VAL
//   tick     : decrement enable (one clk per timebase tick)
//   load     : load load_val this cycle (has priority over tick)
//   load_val : value to load
//   count    : current count; holds at zero rather than wrapping
module tick_countdown #(
  parameter int                 TIMER_W = 8,
  parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count
);

  logic [TIMER_W-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RST_VAL;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/multi_phase_light_controller.sv
// multi_phase_light_controller -- round-robin traffic controller for NUM_PHASES
// approaches with a shared pedestrian phase.
//   clk         : clock
//   rst         : synchronous active-high reset
//   tick        : timebase enable; state durations are counted in ticks
//   car_req     : level car-present sense, one bit per phase
//   ped_req     : pedestrian button, sampled every clk
//   light       : per-phase one-hot lamp, phase i at [3i+2:3i]
//   walk        : per-phase walk signal
//   phase_idx   : phase currently green, or the last one served
//   ped_pending : latched pedestrian request
module multi_phase_light_controller
  import traffic_pkg::*;
#(
  parameter  int NUM_PHASES   = 4,
  parameter  int TIMER_W      = 8,
  parameter  int GREEN_TICKS  = 10,
  parameter  int YELLOW_TICKS = 5,
  parameter  int PED_TICKS    = 15,
  parameter  int ALLRED_TICKS = 1,
  localparam int IDX_W        = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [NUM_PHASES-1:0]   car_req,
  input  logic                    ped_req,
  output logic [3*NUM_PHASES-1:0] light,
  output logic [NUM_PHASES-1:0]   walk,
  output logic [IDX_W-1:0]        phase_idx,
  output logic                    ped_pending
);

  state_e             r_state;
  state_e             w_next_state;
  logic [IDX_W-1:0]   r_phase_idx;
  logic [IDX_W-1:0]   w_next_idx;
  logic               r_ped_pending;
  logic               w_ped_clear;
  logic [TIMER_W-1:0] w_count;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_load;
  logic               w_expire;
  logic [NUM_PHASES-1:0] w_own_mask;
  logic               w_own_req;
  logic               w_other_req;

  // First phase with a request, searching upward from last+1 with wrap;
  // with no requests the rotation simply advances by one.
  function automatic logic [IDX_W-1:0] rr_select(input logic [NUM_PHASES-1:0] req,
                                                 input logic [IDX_W-1:0]      last);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               p;
    sel   = IDX_W'((int'(last) + 1) % NUM_PHASES);
    found = 1'b0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      p = (int'(last) + k) % NUM_PHASES;
      if (!found && ((req & (NUM_PHASES'(1) << p)) != '0)) begin
        sel   = IDX_W'(p);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  tick_countdown #(
    .TIMER_W (TIMER_W),
    .RST_VAL (TIMER_W'(ALLRED_TICKS))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (w_load),
    .load_val (w_load_val),
    .count    (w_count)
  );

  // The state ends on the tick that would take the timer from 1 to 0; the
  // reload on that same edge means the timer never actually reaches zero.
  assign w_expire    = tick && (w_count == TIMER_W'(1));
  assign w_own_mask  = NUM_PHASES'(1) << r_phase_idx;
  assign w_own_req   = (car_req & w_own_mask) != '0;
  assign w_other_req = (car_req & ~w_own_mask) != '0;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_phase_idx;
    w_load       = 1'b0;
    w_load_val   = TIMER_W'(ALLRED_TICKS);
    w_ped_clear  = 1'b0;
    if (w_expire) begin
      // Every expiry enters a state (possibly the same GREEN), so it always reloads.
      w_load = 1'b1;
      case (r_state)
        ST_ALLRED: begin
          if (r_ped_pending) begin
            w_next_state = ST_PED;
            w_load_val   = TIMER_W'(PED_TICKS);
          end else begin
            w_next_state = ST_GREEN;
            w_load_val   = TIMER_W'(GREEN_TICKS);
            w_next_idx   = rr_select(car_req, r_phase_idx);
          end
        end
        ST_GREEN: begin
          // Hold green only while this approach is the sole demand.
          if (!w_other_req && !r_ped_pending && w_own_req) begin
            w_next_state = ST_GREEN;
            w_load_val   = TIMER_W'(GREEN_TICKS);
          end else begin
            w_next_state = ST_YELLOW;
            w_load_val   = TIMER_W'(YELLOW_TICKS);
          end
        end
        ST_YELLOW: begin
          w_next_state = ST_ALLRED;
          w_load_val   = TIMER_W'(ALLRED_TICKS);
        end
        ST_PED: begin
          w_next_state = ST_ALLRED;
          w_load_val   = TIMER_W'(ALLRED_TICKS);
          w_ped_clear  = 1'b1;
        end
        default: begin
          w_next_state = ST_ALLRED;
          w_load_val   = TIMER_W'(ALLRED_TICKS);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_ALLRED;
      r_phase_idx   <= IDX_W'(NUM_PHASES - 1);  // phase 0 is searched first
      r_ped_pending <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_phase_idx <= w_next_idx;
      // A press in the PED-expiry cycle must survive the clear.
      if (ped_req) begin
        r_ped_pending <= 1'b1;
      end else if (w_ped_clear) begin
        r_ped_pending <= 1'b0;
      end
    end
  end

  // Lamp and walk decode from registered state only.
  always_comb begin
    light = {NUM_PHASES{LIGHT_RED}};
    walk  = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (IDX_W'(i) == r_phase_idx) begin
        if (r_state == ST_GREEN) begin
          light[3*i +: 3] = LIGHT_GREEN;
          walk[i]         = 1'b1;
        end else if (r_state == ST_YELLOW) begin
          light[3*i +: 3] = LIGHT_YELLOW;
        end
      end
    end
    if (r_state == ST_PED) begin
      walk = '1;
    end
  end

  assign phase_idx   = r_phase_idx;
  assign ped_pending = r_ped_pending;

endmodule

// File: tb/tb_multi_phase_light_controller.sv
// tb_multi_phase_light_controller -- directed, table-driven bench for
// multi_phase_light_controller with NUM_PHASES=4, GREEN=3, YELLOW=2, PED=4,
// ALLRED=1. Each table row is one clk: inputs applied, then outputs expected
// after the edge. A hand-written sequence covers the slow-tick case.
module tb_multi_phase_light_controller;
  import traffic_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  car_req = 4'b0;
  logic        ped_req = 1'b0;
  logic [11:0] light;
  logic [3:0]  walk;
  logic [1:0]  phase_idx;
  logic        ped_pending;

  multi_phase_light_controller #(
    .NUM_PHASES   (4),
    .TIMER_W      (8),
    .GREEN_TICKS  (3),
    .YELLOW_TICKS (2),
    .PED_TICKS    (4),
    .ALLRED_TICKS (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .car_req     (car_req),
    .ped_req     (ped_req),
    .light       (light),
    .walk        (walk),
    .phase_idx   (phase_idx),
    .ped_pending (ped_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        tick;
    logic [3:0]  car;
    logic        ped;
    logic [11:0] light;
    logic [3:0]  walk;
    logic [1:0]  idx;
    logic        pend;
    int          scen;
  } vec_t;

  localparam logic [11:0] ALL_RED = 12'h249;

  vec_t vecs[$];
  int   cur_scen = 0;
  int   n_vec    = 0;
  int   n_fail   = 0;

  function automatic logic [11:0] lamp(input int p, input logic [2:0] c);
    logic [11:0] l;
    l = ALL_RED;
    l[3*p +: 3] = c;
    return l;
  endfunction

  task automatic add(input logic r, input logic t, input logic [3:0] car, input logic pd,
                     input logic [11:0] l, input logic [3:0] w, input logic [1:0] ix,
                     input logic pn);
    vec_t v;
    v.rst = r; v.tick = t; v.car = car; v.ped = pd;
    v.light = l; v.walk = w; v.idx = ix; v.pend = pn; v.scen = cur_scen;
    vecs.push_back(v);
  endtask

  // Reset row: every other input is active to show reset overrides them.
  task automatic rs();
    add(1'b1, 1'b1, 4'hF, 1'b1, ALL_RED, 4'b0000, 2'd3, 1'b0);
  endtask

  task automatic g(input logic [3:0] car, input int p, input logic pn, input int n);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b1, car, 1'b0, lamp(p, LIGHT_GREEN), 4'(1 << p), 2'(p), pn);
  endtask

  task automatic y(input logic [3:0] car, input int p, input logic pn, input int n);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b1, car, 1'b0, lamp(p, LIGHT_YELLOW), 4'b0000, 2'(p), pn);
  endtask

  task automatic ar(input logic [3:0] car, input int ix, input logic pn, input int n);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b1, car, 1'b0, ALL_RED, 4'b0000, 2'(ix), pn);
  endtask

  task automatic pd(input logic [3:0] car, input int ix, input logic pn, input int n);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b1, car, 1'b0, ALL_RED, 4'b1111, 2'(ix), pn);
  endtask

  // Ped press during phase 1 green, through the whole PED phase.
  task automatic ped_prefix();
    rs();
    g(4'b0, 0, 1'b0, 3); y(4'b0, 0, 1'b0, 2); ar(4'b0, 0, 1'b0, 1);
    g(4'b0, 1, 1'b0, 1);
    add(1'b0, 1'b1, 4'b0, 1'b1, lamp(1, LIGHT_GREEN), 4'b0010, 2'd1, 1'b1);
    g(4'b0, 1, 1'b1, 1); y(4'b0, 1, 1'b1, 2); ar(4'b0, 1, 1'b1, 1);
    pd(4'b0, 1, 1'b1, 4);
  endtask

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got light=%h walk=%b idx=%0d pend=%b, expected light=%h walk=%b idx=%0d pend=%b",
               name, act[18:7], act[6:3], act[2:1], act[0], exp[18:7], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    int gcnt;

    // 1: free rotation 0,1,2,3,0 with no demand; tick low freezes ALLRED first.
    cur_scen = 1;
    rs();
    add(1'b0, 1'b0, 4'b0, 1'b0, ALL_RED, 4'b0000, 2'd3, 1'b0);
    add(1'b0, 1'b0, 4'b0, 1'b0, ALL_RED, 4'b0000, 2'd3, 1'b0);
    g(4'b0, 0, 1'b0, 3); y(4'b0, 0, 1'b0, 2); ar(4'b0, 0, 1'b0, 1);
    g(4'b0, 1, 1'b0, 3); y(4'b0, 1, 1'b0, 2); ar(4'b0, 1, 1'b0, 1);
    g(4'b0, 2, 1'b0, 3); y(4'b0, 2, 1'b0, 2); ar(4'b0, 2, 1'b0, 1);
    g(4'b0, 3, 1'b0, 3); y(4'b0, 3, 1'b0, 2); ar(4'b0, 3, 1'b0, 1);
    g(4'b0, 0, 1'b0, 1);

    // 2: sole demand on phase 2 holds green; dropping it yellows on the 3-aligned expiry.
    cur_scen = 2;
    rs();
    g(4'b0100, 2, 1'b0, 8);
    g(4'b0000, 2, 1'b0, 1);
    y(4'b0000, 2, 1'b0, 2); ar(4'b0000, 2, 1'b0, 1);
    g(4'b0000, 3, 1'b0, 1);

    // 3: demand on 0 and 2 -> phase 1 is skipped.
    cur_scen = 3;
    rs();
    g(4'b0101, 0, 1'b0, 3); y(4'b0101, 0, 1'b0, 2); ar(4'b0101, 0, 1'b0, 1);
    g(4'b0101, 2, 1'b0, 1);

    // 4: ped press in phase 1 green -> PED, then rotation resumes at phase 2.
    cur_scen = 4;
    ped_prefix();
    ar(4'b0, 1, 1'b0, 1);
    g(4'b0, 2, 1'b0, 1);

    // 5: press in the PED-expiry cycle keeps the request and a second PED follows.
    cur_scen = 5;
    ped_prefix();
    add(1'b0, 1'b1, 4'b0, 1'b1, ALL_RED, 4'b0000, 2'd1, 1'b1);
    pd(4'b0, 1, 1'b1, 4);
    ar(4'b0, 1, 1'b0, 1);
    g(4'b0, 2, 1'b0, 1);

    // 6: reset mid-PED, with a press at the ALLRED expiry that goes to green first.
    cur_scen = 6;
    rs();
    add(1'b0, 1'b1, 4'b0, 1'b1, lamp(0, LIGHT_GREEN), 4'b0001, 2'd0, 1'b1);
    g(4'b0, 0, 1'b1, 2); y(4'b0, 0, 1'b1, 2); ar(4'b0, 0, 1'b1, 1);
    pd(4'b0, 0, 1'b1, 2);
    add(1'b1, 1'b1, 4'b0, 1'b0, ALL_RED, 4'b0000, 2'd3, 1'b0);
    g(4'b0, 0, 1'b0, 1);

    // 7: reset mid-GREEN of a held phase.
    cur_scen = 7;
    rs();
    g(4'b0001, 0, 1'b0, 2);
    add(1'b1, 1'b1, 4'b0001, 1'b0, ALL_RED, 4'b0000, 2'd3, 1'b0);
    g(4'b0001, 0, 1'b0, 1);

    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      tick    = vecs[i].tick;
      car_req = vecs[i].car;
      ped_req = vecs[i].ped;
      step();
      check($sformatf("s%0d_row%0d", vecs[i].scen, i),
            {light, walk, phase_idx, ped_pending},
            {vecs[i].light, vecs[i].walk, vecs[i].idx, vecs[i].pend});
    end

    // Slow timebase: tick every 4th clk stretches GREEN to 12 clk; reset mid-YELLOW.
    rst = 1'b1; tick = 1'b1; car_req = 4'b0; ped_req = 1'b0;
    step();
    check("slow_reset", {light, walk, phase_idx, ped_pending}, {ALL_RED, 4'b0000, 2'd3, 1'b0});
    rst  = 1'b0;
    gcnt = 0;
    for (int c = 0; c < 14; c++) begin
      tick = (c % 4 == 0);
      step();
      if ({light, walk} == {lamp(0, LIGHT_GREEN), 4'b0001}) gcnt++;
    end
    check_int("slow_green_clks", gcnt, 12);
    check("slow_mid_yellow", {light, walk, phase_idx, ped_pending},
          {lamp(0, LIGHT_YELLOW), 4'b0000, 2'd0, 1'b0});
    rst  = 1'b1;
    tick = 1'b0;
    step();
    check("slow_rst_yellow", {light, walk, phase_idx, ped_pending}, {ALL_RED, 4'b0000, 2'd3, 1'b0});
    rst  = 1'b0;
    tick = 1'b1;
    step();
    check("slow_after_rst", {light, walk, phase_idx, ped_pending},
          {lamp(0, LIGHT_GREEN), 4'b0001, 2'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
